// File: rtl/imem_loader_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_responder_pkg : shared constants and state type for the
// instruction-memory loader/responder.   Rev 1.0
// ---------------------------------------------------------------------------
package imem_loader_responder_pkg;

  // addi x0,x0,0 -- returned for any fetch that cannot be served from RAM
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_responder_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_responder_word_packer : assembles loader bytes little-endian
// into 32-bit words; emits a word on the 4th byte or on the last byte.  Rev 1.0
// ---------------------------------------------------------------------------
module imem_loader_responder_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_last_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o
);

  logic [1:0]  idx_q;
  logic [23:0] acc_q;
  logic [31:0] word_d;

  // acc_q is cleared after every emitted word, so bytes not yet seen read as 0
  always_comb begin
    word_d       = {8'h00, acc_q} | ({24'h000000, byte_data_i} << {idx_q, 3'b000});
    word_valid_o = byte_valid_i && ((idx_q == 2'd3) || byte_last_i);
    word_data_o  = word_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      acc_q <= 24'h000000;
    end else if (byte_valid_i) begin
      if (word_valid_o) begin
        idx_q <= 2'd0;
        acc_q <= 24'h000000;
      end else begin
        idx_q <= idx_q + 2'd1;
        acc_q <= word_d[23:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_responder : byte-stream loaded instruction RAM with a 1-cycle
// pipelined fetch port; holds the core in reset until the image is resident.
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_loader_responder
  import imem_loader_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  output logic        cpu_rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] LAST_WPTR = (AW+1)'(DEPTH_WORDS - 1);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  imem_state_t state_q;
  logic        load_ready_q;
  logic        load_done_q;
  logic        cpu_rst_n_q;
  // Doubles as the loaded-word count: every write advances it exactly once
  logic [AW:0] wptr_q;

  logic        byte_acc;
  logic        word_valid;
  logic [31:0] word_data;
  logic        fetch_acc;
  logic [29:0] fetch_idx;
  logic        fetch_bad;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_q;
  logic        fetch_valid_q;
  logic        nop_sel_q;
  logic        fetch_err_q;

  assign byte_acc  = load_valid && load_ready_q;
  assign fetch_acc = fetch_req && (state_q == RUN);
  assign fetch_idx = fetch_addr[31:2];
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_idx >= DEPTH_IDX) ||
                     (fetch_idx >= 30'(wptr_q));

  imem_loader_responder_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (byte_acc),
    .byte_data_i  (load_byte),
    .byte_last_i  (load_last),
    .word_valid_o (word_valid),
    .word_data_o  (word_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      load_ready_q <= 1'b1;
      load_done_q  <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      wptr_q       <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (word_valid) begin
            wptr_q <= wptr_q + 1'b1;
            if (load_last || (wptr_q == LAST_WPTR)) begin
              state_q      <= RUN;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          cpu_rst_n_q <= load_done_q;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // RAM has no reset so it maps onto block RAM; loads and fetches never overlap
  always_ff @(posedge clk) begin
    if (word_valid) mem[wptr_q[AW-1:0]] <= word_data;
    if (fetch_acc)  rd_q <= mem[fetch_addr[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      nop_sel_q     <= 1'b1;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) begin
        nop_sel_q   <= fetch_bad;
        fetch_err_q <= fetch_bad;
      end
    end
  end

  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = nop_sel_q ? NOP_INSTR : rd_q;
  assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_loader_responder : directed, table-driven bench for the loader and
// fetch responder.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_loader_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        cpu_rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } fvec_t;

  fvec_t vec [7];

  imem_loader_responder #(.DEPTH_WORDS(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .cpu_rst_n   (cpu_rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All driving happens 1 time unit after a rising edge; checks precede it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fetch_one(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_instr, input logic exp_err);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
    chk({name, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    chk({name, "_instr"}, fetch_instr, exp_instr);
    chk({name, "_err"},   {31'd0, fetch_err}, {31'd0, exp_err});
  endtask

  initial begin
    vec[0] = '{32'h0000_0000, 32'h0050_0013, 1'b0};
    vec[1] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
    vec[2] = '{32'h0000_0002, NOP,           1'b1};
    vec[3] = '{32'h0000_0008, NOP,           1'b1};
    vec[4] = '{32'h0000_0040, NOP,           1'b1};
    vec[5] = '{32'h4000_0000, NOP,           1'b1};
    vec[6] = '{32'h0000_0000, 32'h0050_0013, 1'b0};

    load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
    fetch_req  = 1'b0; fetch_addr = 32'h0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_load_ready",  {31'd0, load_ready},  32'd1);
    chk("rst_load_done",   {31'd0, load_done},   32'd0);
    chk("rst_cpu_rst_n",   {31'd0, cpu_rst_n},   32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fetch_instr", fetch_instr,          NOP);
    chk("rst_fetch_err",   {31'd0, fetch_err},   32'd0);
    rst_n = 1'b1;

    // Image 1 with a fetch request held during LOAD and idle gaps between bytes
    fetch_req = 1'b1; fetch_addr = 32'h0;
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("load_fetch_ignored", {31'd0, fetch_valid}, 32'd0);
    tick(); tick();
    chk("load_fetch_ignored2", {31'd0, fetch_valid}, 32'd0);
    fetch_req = 1'b0;
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("mid_load_done", {31'd0, load_done}, 32'd0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b1);
    chk("img1_load_done",  {31'd0, load_done},  32'd1);
    chk("img1_load_ready", {31'd0, load_ready}, 32'd0);
    chk("img1_cpu_rst_early", {31'd0, cpu_rst_n}, 32'd0);
    tick();
    chk("img1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

    // Back-to-back fetches from the table
    for (int i = 0; i < 7; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = vec[i].addr;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, fetch_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), fetch_instr, vec[i].instr);
      chk($sformatf("vec%0d_err", i),   {31'd0, fetch_err}, {31'd0, vec[i].err});
    end
    fetch_req  = 1'b0;
    fetch_addr = 32'h0000_0002;
    tick();
    chk("idle_valid", {31'd0, fetch_valid}, 32'd0);
    chk("idle_hold_instr", fetch_instr, 32'h0050_0013);
    chk("idle_hold_err", {31'd0, fetch_err}, 32'd0);
    fetch_one("err_hold_src", 32'h0000_0006, NOP, 1'b1);
    tick();
    chk("idle_hold_err1", {31'd0, fetch_err}, 32'd1);
    chk("run_done_stays", {31'd0, load_done}, 32'd1);

    // Fill to capacity without load_last
    do_reset();
    chk("rst2_load_done", {31'd0, load_done}, 32'd0);
    chk("rst2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (i == 4 * DEPTH - 1)
        chk("full_pre_done", {31'd0, load_done}, 32'd0);
      send_byte(8'(i), 1'b0);
    end
    chk("full_load_done",  {31'd0, load_done},  32'd1);
    chk("full_load_ready", {31'd0, load_ready}, 32'd0);
    send_byte(8'hFF, 1'b0);
    chk("full_refuse_ready", {31'd0, load_ready}, 32'd0);
    chk("full_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    fetch_one("full_w0",  32'h0000_0000, 32'h0302_0100, 1'b0);
    fetch_one("full_w15", 32'h0000_003C, 32'h3F3E_3D3C, 1'b0);
    fetch_one("full_oor", 32'h0000_0040, NOP, 1'b1);

    // Second image interrupted by reset, then a short 5-byte image
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_load_done",  {31'd0, load_done},  32'd0);
    chk("midrst_cpu_rst_n",  {31'd0, cpu_rst_n},  32'd0);
    chk("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    rst_n = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    chk("img3_load_done", {31'd0, load_done}, 32'd1);
    tick();
    chk("img3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    fetch_one("img3_w0", 32'h0000_0000, 32'hDDCC_BBAA, 1'b0);
    fetch_one("img3_w1", 32'h0000_0004, 32'h0000_00EE, 1'b0);
    fetch_one("img3_w2_unloaded", 32'h0000_0008, NOP, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
